ram_bank_ctrl: RTL and testbench
================================

// Module: ram_bank_ctrl
// PURPOSE
//  Parametrised single-clock RAM bank; next generation of the 32x256 ram block.
//  - Separate write and read ports; per-byte write enables; registered read with a valid strobe.
//  - Write-first forwarding on same-address read/write.
//  - Hardware clear engine zero-fills the array after reset or on request.
//  - Sits between datapath masters and storage; also the building block for wider/deeper banks.
// PARAMETERS
//  DW     32       data width in bits; must be a multiple of 8
//  AW     8        address width in bits
//  DEPTH  2**AW    number of words; must satisfy 1 <= DEPTH <= 2**AW
// PORTS
//  clk     in   1        single clock; all logic rising-edge
//  rst_n   in   1        reset, asynchronous assert, active-low
//  clr     in   1        pulse: restart zero-fill of the whole array
//  busy    out  1        1 while the clear engine owns the array
//  we      in   1        write request
//  wadr    in   AW       write address
//  wdata   in   DW       write data
//  wbe     in   DW/8     byte enables; bit i covers wdata[8i+7:8i]
//  re      in   1        read request
//  radr    in   AW       read address
//  rdata   out  DW       read data, registered
//  rvalid  out  1        1 for one cycle when rdata carries a new read result
// BEHAVIOUR
//  Reset: rst_n=0 asynchronously forces:
//   - rdata=0, rvalid=0, busy=1
//   - state=CLEAR, clear pointer cptr=0
//  Array cells have no reset; contents are defined only by the clear sweep.
//  FSM states:
//   - CLEAR: each cycle writes 0 to mem[cptr], then cptr++; busy=1.
//     After writing cptr=DEPTH-1 -> IDLE (busy=0 from the next cycle).
//     The sweep takes exactly DEPTH cycles after rst_n rises.
//   - IDLE: normal access.
//     clr=1 -> CLEAR with cptr=0 next cycle; an access presented in that same cycle is still served.
//   - clr=1 while in CLEAR restarts the sweep at cptr=0.
//  While busy=1:
//   - we and re are ignored (dropped, not queued).
//   - rvalid=0; rdata holds its value.
//  Write (IDLE, we=1, wadr<DEPTH): for each lane i with wbe[i]=1, mem[wadr] lane i <= wdata lane i.
//   - Lanes with wbe[i]=0 are unchanged.
//   - wbe=0 is a no-op.
//   - wadr>=DEPTH: the write is discarded.
//  Read (IDLE, re=1): latency 1.
//   - Request sampled at edge N; rdata/rvalid are updated at edge N, visible in cycle N+1.
//   - rvalid=1 for exactly that one cycle, then 0 unless re stays asserted.
//   - Back-to-back reads give one result per cycle.
//   - radr>=DEPTH: rdata=0, rvalid=1.
//   - re=0: rdata holds its last value, rvalid=0.
//  Same-cycle we&re with wadr==radr (write-first): rdata = the old word with the enabled lanes
//   replaced by wdata.
//  Reset mid-operation: the pending read is lost (rvalid=0); a write in the reset cycle is not
//   guaranteed; the sweep restarts.
// STRUCTURE
//  Shared package ram_pkg:
//   - state encoding ST_IDLE / ST_CLEAR
//   - localparam NBE = DW/8
//   - helper function for byte-lane merging (merge old word, new word, byte enables)
//  Sub-module ram_array:
//   - plain DEPTH x DW storage, one write port with per-byte enables, one read port
//     with asynchronous (combinational) read; no reset
//   - ram_bank_ctrl registers that read output, so the behaviour above keeps 1-cycle latency
//   - ram_bank_ctrl owns the FSM, write muxing (clear vs user), forwarding and range checks
//  Elaboration-time check: DW%8==0 and DEPTH<=2**AW; otherwise $error.
// TESTING
//  Default parameters unless stated otherwise.
//  1. Release rst_n -> busy=1 for exactly 256 cycles, then 0; reads of adr 0,128,255 give rdata=0 with rvalid=1.
//  2. Writes, wbe=4'hF: adr1=50, adr2=2, adr3=7, adr4=9; then read adr 1..4 back-to-back
//     -> 50,2,7,9 on consecutive cycles, rvalid=1 each cycle.
//  3. Partial write:
//     - write adr5=32'hAABBCCDD with wbe=F, then 32'h11223344 with wbe=4'b0101 -> read 32'hAA22CC44.
//     - write with wbe=0 -> word unchanged.
//  4. Same-cycle write adr7=32'h12345678 (wbe=4'b0011) and read adr7, where adr7 holds 32'hFFFFFFFF
//     -> rdata=32'hFFFF5678 next cycle.
//  5. Pulse clr after scenario 2:
//     - we/re during busy are dropped with rvalid=0.
//     - once busy falls, adr1..4 read 0.
//     - a second clr mid-sweep extends busy to 256 cycles from that second pulse.
//  6. DEPTH=200, AW=8:
//     - write adr 210 -> no effect, adr 210-200=10 unchanged.
//     - read adr 210 -> rdata=0, rvalid=1.
//     - assert rst_n=0 during a read -> rvalid=0 immediately.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding, default geometry and byte-lane merge helper for the RAM bank.
package ram_pkg;
    localparam int DEF_DW  = 32;
    localparam int DEF_AW  = 8;
    localparam int DEF_NBE = DEF_DW / 8;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic be);
        return be ? new_b : old_b;
    endfunction
endpackage

// File: rtl/ram_bank_ctrl_if.sv
// ram_bank_ctrl_if: clear, write and read channels of the RAM bank.
interface ram_bank_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic            clr;
    logic            busy;
    logic            we;
    logic [AW-1:0]   wadr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wbe;
    logic            re;
    logic [AW-1:0]   radr;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    modport master (output clr, we, wadr, wdata, wbe, re, radr, input busy, rdata, rvalid);
    modport slave  (input clr, we, wadr, wdata, wbe, re, radr, output busy, rdata, rvalid);
endinterface

// File: rtl/ram_array.sv
// ram_array: plain DEPTH x DW storage with per-byte write enables and combinational read.
module ram_array
    import ram_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = 2 ** AW
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   wadr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wbe_i,
    input  logic [AW-1:0]   radr_i,
    output logic [DW-1:0]   rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DW / 8; i++) begin
                mem_q[wadr_i][8*i +: 8] <= merge_byte(mem_q[wadr_i][8*i +: 8], wdata_i[8*i +: 8], wbe_i[i]);
            end
        end
    end
    assign rdata_o = mem_q[radr_i];
endmodule

// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl: RAM bank with byte-enable writes, registered write-first reads
// and a zero-fill clear engine that owns the array after reset or on clr.
module ram_bank_ctrl
    import ram_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = 2 ** AW
) (
    input logic            clk,
    input logic            rst_n,
    ram_bank_ctrl_if.slave bus
);
    localparam int            NBE  = DW / 8;
    localparam logic [AW:0]   LIM  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    if (DW % 8 != 0 || DEPTH < 1 || DEPTH > 2 ** AW) begin : g_bad_cfg
        $error("ram_bank_ctrl: DW must be a multiple of 8 and 1 <= DEPTH <= 2**AW");
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   cptr_q, cptr_d;
    logic [DW-1:0]   rdata_q, rdata_d, arr_rdata, fwd_rdata;
    logic            rvalid_q, rvalid_d;
    logic            idle, wr_ok, rd_in, rd_hit;
    logic            mem_we;
    logic [AW-1:0]   mem_wadr;
    logic [DW-1:0]   mem_wdata;
    logic [NBE-1:0]  mem_wbe;

    always_comb begin
        idle      = state_q == ST_IDLE;
        wr_ok     = idle && bus.we && ({1'b0, bus.wadr} < LIM);
        rd_in     = {1'b0, bus.radr} < LIM;
        rd_hit    = wr_ok && bus.wadr == bus.radr;
        state_d   = bus.clr ? ST_CLEAR : (!idle && cptr_q == LAST) ? ST_IDLE : state_q;
        cptr_d    = (bus.clr || idle || cptr_q == LAST) ? '0 : cptr_q + 1'b1;
        mem_we    = !idle || wr_ok;
        mem_wadr  = idle ? bus.wadr : cptr_q;
        mem_wdata = idle ? bus.wdata : '0;
        mem_wbe   = idle ? bus.wbe : '1;
        rvalid_d  = idle && bus.re;
        rdata_d   = !rvalid_d ? rdata_q : rd_in ? fwd_rdata : '0;
    end

    // write-first: lanes being written this cycle bypass the array on an address match
    for (genvar i = 0; i < NBE; i++) begin : g_fwd
        assign fwd_rdata[8*i +: 8] = merge_byte(arr_rdata[8*i +: 8], bus.wdata[8*i +: 8], rd_hit && bus.wbe[i]);
    end

    ram_array #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .wadr_i  (mem_wadr),
        .wdata_i (mem_wdata),
        .wbe_i   (mem_wbe),
        .radr_i  (bus.radr),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cptr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cptr_q   <= cptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.busy   = !idle;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_ram_bank_ctrl.sv
// tb_ram_bank_ctrl: scoreboard bench for a full-depth bank and a 200-word bank sharing one clock.
module tb_ram_bank_ctrl;
    logic clk = 1'b0, rst_n0 = 1'b0, rst_n1 = 1'b0;
    always #5 clk = ~clk;

    ram_bank_ctrl_if #(.DW(32), .AW(8)) b0 ();
    ram_bank_ctrl_if #(.DW(32), .AW(8)) b1 ();
    ram_bank_ctrl #(.DW(32), .AW(8)) u0 (.clk(clk), .rst_n(rst_n0), .bus(b0));
    ram_bank_ctrl #(.DW(32), .AW(8), .DEPTH(200)) u1 (.clk(clk), .rst_n(rst_n1), .bus(b1));

    int total = 0, bad = 0;
    logic [31:0] q0[$], q1[$];
    logic [31:0] mdl[2][256];
    int cnt[2];
    logic [31:0] last[2];
    logic rv[2];
    int dep[2] = '{256, 200};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    // one clock: drive DUT d, advance the models of both banks, then check both banks
    task automatic step(input int d, input logic c, input logic w, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic r, input logic [7:0] ra);
        logic [31:0] x, dt;
        logic s, rn, bz, vl;
        {b0.clr, b0.we, b0.wadr, b0.wdata, b0.wbe, b0.re, b0.radr} = (d == 0) ? {c, w, wa, wd, be, r, ra} : 55'd0;
        {b1.clr, b1.we, b1.wadr, b1.wdata, b1.wbe, b1.re, b1.radr} = (d == 1) ? {c, w, wa, wd, be, r, ra} : 55'd0;
        @(posedge clk);
        for (int e = 0; e < 2; e++) begin
            s = e == d;
            rn = (e == 0) ? rst_n0 : rst_n1;
            rv[e] = 1'b0;
            if (!rn) begin
                cnt[e] = dep[e];
                last[e] = '0;
                for (int a = 0; a < 256; a++) mdl[e][a] = '0;
                if (e == 0) q0.delete(); else q1.delete();
            end else begin
                if (cnt[e] == 0 && s && r) begin
                    x = (int'(ra) < dep[e]) ? mdl[e][ra] : '0;
                    if (w && wa == ra && int'(wa) < dep[e]) x = merge(x, wd, be);
                    if (e == 0) q0.push_back(x); else q1.push_back(x);
                    rv[e] = 1'b1;
                    last[e] = x;
                end
                if (cnt[e] == 0 && s && w && int'(wa) < dep[e]) mdl[e][wa] = merge(mdl[e][wa], wd, be);
                if (s && c) begin
                    cnt[e] = dep[e];
                    for (int a = 0; a < 256; a++) mdl[e][a] = '0;
                end else if (cnt[e] > 0) cnt[e]--;
            end
        end
        #1;
        for (int e = 0; e < 2; e++) begin
            bz = (e == 0) ? b0.busy : b1.busy;
            vl = (e == 0) ? b0.rvalid : b1.rvalid;
            dt = (e == 0) ? b0.rdata : b1.rdata;
            chk($sformatf("busy%0d", e), bz, cnt[e] > 0);
            chk($sformatf("rvalid%0d", e), vl, rv[e]);
            if (rv[e]) chk($sformatf("rdata%0d", e), dt, (e == 0) ? q0.pop_front() : q1.pop_front());
            else chk($sformatf("hold%0d", e), dt, last[e]);
        end
    endtask

    task automatic idle_cyc(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] v, input logic [3:0] be);
        step(d, 0, 1, a, v, be, 0, 0);
    endtask
    task automatic rd(input int d, input logic [7:0] a);
        step(d, 0, 0, 0, 0, 0, 1, a);
    endtask

    initial begin
        idle_cyc(2);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        idle_cyc(257);
        rd(0, 0); rd(0, 128); rd(0, 255);
        wr(0, 1, 50, 4'hF); wr(0, 2, 2, 4'hF); wr(0, 3, 7, 4'hF); wr(0, 4, 9, 4'hF);
        for (int a = 1; a <= 4; a++) rd(0, 8'(a));
        wr(0, 5, 32'hAABBCCDD, 4'hF);
        wr(0, 5, 32'h11223344, 4'b0101);
        rd(0, 5);
        wr(0, 5, 32'h55667788, 4'h0);
        rd(0, 5);
        wr(0, 7, 32'hFFFFFFFF, 4'hF);
        step(0, 0, 1, 7, 32'h12345678, 4'b0011, 1, 7);
        idle_cyc(1);
        step(0, 1, 0, 0, 0, 0, 1, 2);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 8'(k + 1), 32'hDEADBEEF, 4'hF, 1, 8'(k + 1));
        idle_cyc(95);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle_cyc(256);
        for (int a = 1; a <= 4; a++) rd(0, 8'(a));
        wr(1, 10, 32'hCAFEF00D, 4'hF);
        wr(1, 210, 32'hDEADDEAD, 4'hF);
        rd(1, 10);
        rd(1, 210);
        step(1, 0, 1, 210, 32'h01020304, 4'hF, 1, 210);
        rd(1, 10);
        rst_n1 = 1'b0;
        #1;
        chk("rst_rvalid", b1.rvalid, 0);
        chk("rst_rdata", b1.rdata, 0);
        chk("rst_busy", b1.busy, 1);
        idle_cyc(1);
        rst_n1 = 1'b1;
        idle_cyc(201);
        rd(1, 10);
        chk("sb0_left", 32'(q0.size()), 0);
        chk("sb1_left", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
